// File: rtl/ps2_key_if.sv
// ps2_key_if: keyboard line inputs and decoded key outputs of the PS/2 receiver
interface ps2_key_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_on;
    logic       parity_err;
    modport master (output ps2_clk, ps2_data, input key_code, key_ext, key_on, parity_err);
    modport slave (input ps2_clk, ps2_data, output key_code, key_ext, key_on, parity_err);
endinterface

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 frame deserialiser delivering make codes with E0/F0 prefix handling.
// Optional partial-frame timeout enabled by defining PS2_TIMEOUT_EN.
module ps2_key_receiver #(
    parameter int ON_CYCLES      = 10,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input logic     clk,
    input logic     rst,
    ps2_key_if.slave bus
);
    localparam int OW = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
`ifdef PS2_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] to_cnt;
`endif
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t        state;
    logic [1:0]    clk_s, dat_s;
    logic          clk_prev, fall, din;
    logic [2:0]    cnt;
    logic [7:0]    sh, byte_q, key_code;
    logic          par, byte_vld, perr;
    logic          brk, ext, key_ext, key_on, make;
    logic [OW-1:0] on_cnt;
    assign fall = clk_prev & ~clk_s[1];
    assign din  = dat_s[1];
    assign make = byte_vld && byte_q != 8'hE0 && byte_q != 8'hF0 && !brk;
    assign bus.key_code   = key_code;
    assign bus.key_ext    = key_ext;
    assign bus.key_on     = key_on;
    assign bus.parity_err = perr;
    // Two-flop synchronisers for the keyboard lines; idle-high reset avoids a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s    <= 2'b11;
            dat_s    <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_s    <= {clk_s[0], bus.ps2_clk};
            dat_s    <= {dat_s[0], bus.ps2_data};
            clk_prev <= clk_s[1];
        end
    end
    // Frame FSM stepping on ps2_clk falling edges; flags a checked byte for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            par      <= 1'b0;
            byte_q   <= '0;
            byte_vld <= 1'b0;
            perr     <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            byte_vld <= 1'b0;
            perr     <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            to_cnt   <= (fall || state == IDLE) ? '0 : to_cnt + 1'b1;
`endif
            if (fall) begin
                case (state)
                    IDLE: if (!din) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                    DATA: begin
                        sh    <= {din, sh[7:1]};
                        cnt   <= cnt + 1'b1;
                        state <= (cnt == 3'd7) ? PARITY : DATA;
                    end
                    PARITY: begin
                        par   <= din;
                        state <= STOP;
                    end
                    default: begin
                        state    <= IDLE;
                        byte_q   <= sh;
                        byte_vld <= din & ^{sh, par};
                        perr     <= din & ~^{sh, par};
                    end
                endcase
            end
`ifdef PS2_TIMEOUT_EN
            else if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state  <= IDLE;
                cnt    <= '0;
                to_cnt <= '0;
            end
`endif
        end
    end
    // Prefix tracking, make-code latch and key_on pulse timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code <= 8'h00;
            key_ext  <= 1'b0;
            key_on   <= 1'b0;
            on_cnt   <= '0;
            brk      <= 1'b0;
            ext      <= 1'b0;
        end else begin
            if (byte_vld && byte_q == 8'hE0) ext <= 1'b1;
            else if (byte_vld && byte_q == 8'hF0) brk <= 1'b1;
            else if (byte_vld && brk) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (byte_vld) begin
                key_code <= byte_q;
                key_ext  <= ext;
                ext      <= 1'b0;
            end
            if (make) begin
                key_on <= 1'b1;
                on_cnt <= OW'(ON_CYCLES - 1);
            end else if (on_cnt == '0) key_on <= 1'b0;
            else on_cnt <= on_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: directed PS/2 frame tests with hand-computed expectations.
module tb_ps2_key_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    int pulses = 0, on_run = 0, on_len = 0;
    int perr_pulses = 0, perr_run = 0, perr_len = 0;
    logic on_prev = 1'b0, perr_prev = 1'b0;
    int p0, e0;
    ps2_key_if bus();
    ps2_key_receiver #(.ON_CYCLES(10), .TIMEOUT_CYCLES(200)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // Measure key_on and parity_err pulse counts and widths.
    always @(negedge clk) begin
        if (bus.key_on) begin
            on_run = on_prev ? on_run + 1 : 1;
            if (!on_prev) pulses++;
        end else if (on_prev) on_len = on_run;
        on_prev = bus.key_on;
        if (bus.parity_err) begin
            perr_run = perr_prev ? perr_run + 1 : 1;
            if (!perr_prev) perr_pulses++;
        end else if (perr_prev) perr_len = perr_run;
        perr_prev = bus.parity_err;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    function automatic logic [10:0] frame(input logic [7:0] b, input logic flip);
        return {1'b1, ~^b ^ flip, b, 1'b0};
    endfunction
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            tick(5);
            bus.ps2_data = f[i];
            tick(5);
            bus.ps2_clk = 1'b0;
            tick(10);
            bus.ps2_clk = 1'b1;
        end
    endtask
    task automatic send(input logic [7:0] b, input logic flip);
        send_bits(frame(b, flip), 11);
        tick(40);
    endtask
    initial begin
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        tick(3);
        check("rst_code", bus.key_code, 8'h00);
        check("rst_ext", bus.key_ext, 0);
        check("rst_on", bus.key_on, 0);
        check("rst_perr", bus.parity_err, 0);
        rst = 1'b0;
        tick(5);
        p0 = pulses;
        send(8'h16, 0);
        check("t1_code", bus.key_code, 8'h16);
        check("t1_ext", bus.key_ext, 0);
        check("t1_pulses", pulses - p0, 1);
        check("t1_on_len", on_len, 10);
        p0 = pulses;
        send(8'hF0, 0);
        send(8'h16, 0);
        check("t2_code", bus.key_code, 8'h16);
        check("t2_pulses", pulses - p0, 0);
        p0 = pulses;
        send(8'hE0, 0);
        send(8'h75, 0);
        check("t3_code", bus.key_code, 8'h75);
        check("t3_ext", bus.key_ext, 1);
        check("t3_pulses", pulses - p0, 1);
        send(8'h26, 0);
        check("t3b_code", bus.key_code, 8'h26);
        check("t3b_ext", bus.key_ext, 0);
        p0 = pulses;
        e0 = perr_pulses;
        send(8'h26, 1);
        check("t4_perr", perr_pulses - e0, 1);
        check("t4_perr_len", perr_len, 1);
        check("t4_pulses", pulses - p0, 0);
        send(8'h26, 0);
        check("t4b_code", bus.key_code, 8'h26);
        check("t4b_pulses", pulses - p0, 1);
        send(8'h16, 0);
        check("t5_pre_code", bus.key_code, 8'h16);
        send_bits(frame(8'h26, 0), 6);
        tick(3);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_code", bus.key_code, 8'h00);
        check("t5_rst_ext", bus.key_ext, 0);
        check("t5_rst_on", bus.key_on, 0);
        check("t5_rst_perr", bus.parity_err, 0);
        tick(3);
        rst = 1'b0;
        tick(5);
        p0 = pulses;
        send(8'h26, 0);
        check("t5_code", bus.key_code, 8'h26);
        check("t5_pulses", pulses - p0, 1);
        send(8'h16, 0);
        check("t6_pre_code", bus.key_code, 8'h16);
        p0 = pulses;
        send_bits(frame(8'h26, 0), 4);
        tick(300);
        send(8'h26, 0);
`ifdef PS2_TIMEOUT_EN
        check("t6_code", bus.key_code, 8'h26);
        check("t6_pulses", pulses - p0, 1);
`else
        check("t6_code", bus.key_code, 8'h16);
        check("t6_pulses", pulses - p0, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
